// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared types, FSM states and saturating add for the weight-stationary PE
package pe_pkg;
  localparam int OP_WIDTH  = 8;
  localparam int ACC_WIDTH = 20;

  typedef logic signed [OP_WIDTH-1:0]  op_t;
  typedef logic signed [ACC_WIDTH-1:0] acc_t;

  typedef enum logic {IDLE, RUN} pe_state_e;

  // Operands arrive sign-extended to 64 bits; the result is clamped to a signed width-bit range.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int width);
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sum = a + b;
    hi  = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (width - 1));
    if (sum > hi) return hi;
    else if (sum < lo) return lo;
    else return sum;
  endfunction
endpackage

// File: rtl/pe_lane_mac.sv
// rtl/pe_lane_mac.sv - registered signed MAC for one lane; PE_WS_MULTI_SAT_EN selects saturation
module pe_lane_mac import pe_pkg::*; #(
  parameter int OP_W  = OP_WIDTH,
  parameter int ACC_W = ACC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [OP_W-1:0]  w,
  input  logic [OP_W-1:0]  iact,
  input  logic [ACC_W-1:0] psum_in,
  output logic [ACC_W-1:0] psum_out
);
  logic signed [2*OP_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  sum;

  assign prod     = (2*OP_W)'($signed(w)) * (2*OP_W)'($signed(iact));
  assign prod_ext = ACC_W'(prod);

`ifdef PE_WS_MULTI_SAT_EN
  assign sum = ACC_W'(sat_add(64'($signed(psum_in)), 64'(prod_ext), ACC_W));
`else
  assign sum = $signed(psum_in) + prod_ext;
`endif

  always_ff @(posedge clk) begin
    if (rst) psum_out <= '0;
    else if (en) psum_out <= sum;
  end
endmodule

// File: rtl/sync_dp_ram.sv
// rtl/sync_dp_ram.sv - simple dual-port RAM, port A writes, port B registered read
module sync_dp_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 512,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             a_en,
  input  logic [AW-1:0]    a_addr,
  input  logic [WIDTH-1:0] a_data,
  input  logic             b_en,
  input  logic [AW-1:0]    b_addr,
  output logic [WIDTH-1:0] b_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (a_en) mem[a_addr] <= a_data;
    if (b_en) b_data <= mem[b_addr];
  end
endmodule

// File: rtl/pe_ws_multi.sv
// rtl/pe_ws_multi.sv - multi-lane weight-stationary PE with ping/pong weight banks (PE_WS_MULTI_SAT_EN)
module pe_ws_multi import pe_pkg::*; #(
  parameter int OP_WIDTH  = 8,
  parameter int ACC_WIDTH = 20,
  parameter int LANES     = 4,
  parameter int DEPTH     = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AW-1:0]              cfg_len,
  input  logic                       w_valid,
  output logic                       w_ready,
  input  logic [LANES*OP_WIDTH-1:0]  w_data,
  input  logic                       w_last,
  input  logic                       iact_valid,
  output logic                       iact_ready,
  input  logic [OP_WIDTH-1:0]        iact,
  input  logic [LANES*ACC_WIDTH-1:0] psum_in,
  output logic                       psum_valid,
  output logic [LANES*ACC_WIDTH-1:0] psum_out,
  output logic                       pass_done
);
  logic [1:0]    full;
  logic          fill_sel;
  logic          comp_sel;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] len_q;
  pe_state_e     state;

  logic w_fire;
  logic fill_done;
  logic i_fire;
  logic pass_end;

  assign w_ready   = !full[fill_sel];
  assign w_fire    = w_valid && w_ready;
  assign fill_done = w_fire && (w_last || wr_ptr == AW'(DEPTH - 1));
  assign i_fire    = iact_valid && iact_ready;
  // len_q of 0 wraps to DEPTH-1 here, giving a full-depth pass.
  assign pass_end  = i_fire && (rd_ptr == len_q - AW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      fill_sel <= 1'b0;
    end else if (w_fire) begin
      if (fill_done) begin
        wr_ptr   <= '0;
        fill_sel <= ~fill_sel;
      end else begin
        wr_ptr <= wr_ptr + AW'(1);
      end
    end
  end

  // Fill and compute always own opposite banks, so set and clear never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 2'b00;
    end else begin
      if (fill_done) full[fill_sel] <= 1'b1;
      if (pass_end)  full[comp_sel] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      iact_ready <= 1'b0;
      rd_ptr     <= '0;
      len_q      <= '0;
      comp_sel   <= 1'b0;
      pass_done  <= 1'b0;
    end else begin
      pass_done <= pass_end;
      case (state)
        IDLE: begin
          if (full[comp_sel]) begin
            len_q      <= cfg_len;
            rd_ptr     <= '0;
            state      <= RUN;
            iact_ready <= 1'b1;
          end
        end
        RUN: begin
          if (i_fire) begin
            if (pass_end) begin
              rd_ptr   <= '0;
              comp_sel <= ~comp_sel;
              if (full[~comp_sel]) begin
                len_q <= cfg_len;
              end else begin
                state      <= IDLE;
                iact_ready <= 1'b0;
              end
            end else begin
              rd_ptr <= rd_ptr + AW'(1);
            end
          end
        end
        default: begin
          state      <= IDLE;
          iact_ready <= 1'b0;
        end
      endcase
    end
  end

  logic                       v1;
  logic [OP_WIDTH-1:0]        iact_q;
  logic [LANES*ACC_WIDTH-1:0] psum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1         <= 1'b0;
      psum_valid <= 1'b0;
    end else begin
      v1         <= i_fire;
      psum_valid <= v1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_fire) begin
      iact_q <= iact;
      psum_q <= psum_in;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [OP_WIDTH-1:0] w_rd;

    sync_dp_ram #(.WIDTH(OP_WIDTH), .DEPTH(2*DEPTH)) u_ram (
      .clk    (clk),
      .a_en   (w_fire),
      .a_addr ({fill_sel, wr_ptr}),
      .a_data (w_data[i*OP_WIDTH +: OP_WIDTH]),
      .b_en   (i_fire),
      .b_addr ({comp_sel, rd_ptr}),
      .b_data (w_rd)
    );

    pe_lane_mac #(.OP_W(OP_WIDTH), .ACC_W(ACC_WIDTH)) u_mac (
      .clk      (clk),
      .rst      (rst),
      .en       (v1),
      .w        (w_rd),
      .iact     (iact_q),
      .psum_in  (psum_q[i*ACC_WIDTH +: ACC_WIDTH]),
      .psum_out (psum_out[i*ACC_WIDTH +: ACC_WIDTH])
    );
  end
endmodule

// File: tb/tb_pe_ws_multi.sv
// tb/tb_pe_ws_multi.sv - self-checking bench for pe_ws_multi with a handshake-level reference model
module tb_pe_ws_multi;
  localparam int OPW = 8, ACW = 20, LANES = 4, DEPTH = 256, AW = 8;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [AW-1:0]          cfg_len;
  logic                   w_valid, w_ready, w_last;
  logic [LANES*OPW-1:0]   w_data;
  logic                   iact_valid, iact_ready;
  logic [OPW-1:0]         iact;
  logic [LANES*ACW-1:0]   psum_in;
  logic                   psum_valid;
  logic [LANES*ACW-1:0]   psum_out;
  logic                   pass_done;

  always #5 clk = ~clk;

  pe_ws_multi #(.OP_WIDTH(OPW), .ACC_WIDTH(ACW), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cfg_len(cfg_len),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_last(w_last),
    .iact_valid(iact_valid), .iact_ready(iact_ready), .iact(iact), .psum_in(psum_in),
    .psum_valid(psum_valid), .psum_out(psum_out), .pass_done(pass_done)
  );

  int checks = 0, failures = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int lane_expect(input int w, input int a, input int p);
    longint s;
    s = longint'(p) + longint'(w) * longint'(a);
`ifdef PE_WS_MULTI_SAT_EN
    if (s > (longint'(1) << (ACW-1)) - 1) s = (longint'(1) << (ACW-1)) - 1;
    if (s < -(longint'(1) << (ACW-1)))    s = -(longint'(1) << (ACW-1));
`else
    s = s & ((longint'(1) << ACW) - 1);
    if (s >= (longint'(1) << (ACW-1))) s = s - (longint'(1) << ACW);
`endif
    return int'(s);
  endfunction

  // Reference model: bank contents by (bank, lane, index), bank flags, and a 2-deep output schedule.
  int                   mem [2][LANES][DEPTH];
  bit                   mfull [2];
  int                   mfb, mcb, fptr, cidx;
  bit                   sh_v [2];
  logic [LANES*ACW-1:0] sh_d [2];
  bit                   pd_pend;
  int                   fires = 0, outs = 0;

  always @(negedge clk) begin
    int len;
    logic [LANES*ACW-1:0] e;
    if (rst) begin
      mfull[0] = 0; mfull[1] = 0;
      mfb = 0; mcb = 0; fptr = 0; cidx = 0;
      sh_v[0] = 0; sh_v[1] = 0; pd_pend = 0;
      fires = outs;
    end else begin
      check("w_ready", w_ready, !mfull[mfb]);
      check("pass_done", pass_done, pd_pend);
      check("psum_valid", psum_valid, sh_v[1]);
      if (psum_valid && sh_v[1]) begin
        outs++;
        for (int l = 0; l < LANES; l++)
          check($sformatf("psum_lane%0d", l), $signed(psum_out[l*ACW +: ACW]), $signed(sh_d[1][l*ACW +: ACW]));
      end
      sh_v[1] = sh_v[0]; sh_d[1] = sh_d[0]; sh_v[0] = 0; pd_pend = 0;
      if (w_valid && w_ready) begin
        for (int l = 0; l < LANES; l++) mem[mfb][l][fptr] = $signed(w_data[l*OPW +: OPW]);
        if (w_last || fptr == DEPTH-1) begin
          mfull[mfb] = 1; mfb ^= 1; fptr = 0;
        end else fptr++;
      end
      if (iact_valid && iact_ready) begin
        len = (cfg_len == 0) ? DEPTH : int'(cfg_len);
        for (int l = 0; l < LANES; l++)
          e[l*ACW +: ACW] = ACW'(lane_expect(mem[mcb][l][cidx], $signed(iact), $signed(psum_in[l*ACW +: ACW])));
        sh_v[0] = 1; sh_d[0] = e; fires++;
        if (cidx == len-1) begin
          mfull[mcb] = 0; mcb ^= 1; cidx = 0; pd_pend = 1;
        end else cidx++;
      end
    end
  end

  logic [LANES*OPW-1:0] wq [$];
  logic [OPW-1:0]       iq [$];
  logic [LANES*ACW-1:0] pq [$];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [LANES*ACW-1:0] rand_psum(input bit lane0_zero);
    logic [LANES*ACW-1:0] v;
    for (int l = 0; l < LANES; l++) v[l*ACW +: ACW] = ACW'($urandom);
    if (lane0_zero) v[ACW-1:0] = '0;
    return v;
  endfunction

  task automatic send_w(input int gap_pct);
    int n;
    n = wq.size();
    for (int i = 0; i < n; i++) begin
      int waited;
      bit acc;
      w_valid = 0;
      if (gap_pct > 0) while ($urandom_range(99) < gap_pct) tick();
      w_valid = 1; w_data = wq[i]; w_last = (i == n-1); waited = 0; acc = 0;
      while (!acc && waited < 2000) begin
        @(negedge clk); acc = w_ready; tick(); waited++;
      end
      check("w_accept", acc, 1);
    end
    w_valid = 0; w_last = 0; wq.delete();
  endtask

  task automatic send_i(input int gap_pct, output int stalls);
    int n;
    bit started;
    n = iq.size(); stalls = 0; started = 0;
    for (int i = 0; i < n; i++) begin
      int waited;
      bit acc;
      iact_valid = 0;
      if (gap_pct > 0) while ($urandom_range(99) < gap_pct) tick();
      iact_valid = 1; iact = iq[i]; psum_in = pq[i]; waited = 0; acc = 0;
      while (!acc && waited < 2000) begin
        @(negedge clk); acc = iact_ready; tick(); waited++;
        if (!acc && started) stalls++;
      end
      started = 1;
      check("iact_accept", acc, 1);
    end
    iact_valid = 0; iq.delete(); pq.delete();
  endtask

  task automatic wait_iready();
    bit r;
    int n;
    r = 0; n = 0;
    while (!r && n < 200) begin
      @(negedge clk); r = iact_ready; tick(); n++;
    end
    check("iact_ready_wait", r, 1);
  endtask

  typedef struct { int w; int a; int p; int e; } vec_t;
  vec_t vt [8];

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls, outs0, len;
    logic [LANES*OPW-1:0] wv;

`ifdef PE_WS_MULTI_SAT_EN
    vt[2] = '{1, 1, 524287, 524287};
    vt[3] = '{-1, 1, -524288, -524288};
    vt[7] = '{-128, 127, -524000, -524288};
`else
    vt[2] = '{1, 1, 524287, -524288};
    vt[3] = '{-1, 1, -524288, 524287};
    vt[7] = '{-128, 127, -524000, 508320};
`endif
    vt[0] = '{-3, 5, 100, 85};
    vt[1] = '{-128, -128, 0, 16384};
    vt[4] = '{127, -128, -5, -16261};
    vt[5] = '{0, 77, 12345, 12345};
    vt[6] = '{127, 127, -100, 16029};

    rst = 1; cfg_len = 0; w_valid = 0; w_last = 0; w_data = '0;
    iact_valid = 0; iact = '0; psum_in = '0;
    tick(); tick();
    @(negedge clk);
    check("rst_w_ready", w_ready, 1);
    check("rst_iact_ready", iact_ready, 0);
    check("rst_psum_valid", psum_valid, 0);
    check("rst_psum_out", psum_out, 0);
    check("rst_pass_done", pass_done, 0);
    tick();
    rst = 0;

    // Four-beat pass with lane0 weights 1..4 and unit activations.
    cfg_len = 4;
    for (int i = 0; i < 4; i++) wq.push_back({24'($urandom), 8'(i + 1)});
    send_w(0);
    @(negedge clk); check("ready_lag0", iact_ready, 0);
    tick();
    @(negedge clk); check("ready_lag1", iact_ready, 1);
    tick();
    for (int j = 1; j <= 8; j++) begin
      iact_valid = (j <= 4); iact = 8'd1; psum_in = rand_psum(1);
      @(negedge clk);
      check("t1_iact_ready", iact_ready, j <= 4);
      check("t1_psum_valid", psum_valid, j >= 3 && j <= 6);
      if (j >= 3 && j <= 6) check("t1_lane0", $signed(psum_out[ACW-1:0]), j - 2);
      check("t1_pass_done", pass_done, j == 5);
      tick();
    end

    // Single-beat passes over a table of signed and overflow cases.
    cfg_len = 1;
    for (int k = 0; k < 8; k++) begin
      bit got;
      for (int l = 0; l < LANES; l++) wv[l*OPW +: OPW] = OPW'(vt[k].w);
      wq.push_back(wv);
      send_w(0);
      wait_iready();
      iact_valid = 1; iact = OPW'(vt[k].a);
      for (int l = 0; l < LANES; l++) psum_in[l*ACW +: ACW] = ACW'(vt[k].p);
      tick();
      iact_valid = 0;
      got = 0;
      for (int c = 0; c < 10 && !got; c++) begin
        @(negedge clk);
        if (psum_valid) begin
          got = 1;
          for (int l = 0; l < LANES; l++)
            check($sformatf("vec%0d_lane%0d", k, l), $signed(psum_out[l*ACW +: ACW]), vt[k].e);
        end
        tick();
      end
      check($sformatf("vec%0d_seen", k), got, 1);
    end

    // Ping-pong with backpressure: passes of 8, later fills only 6 beats deep.
    cfg_len = 8;
    fork
      begin
        for (int s = 0; s < 4; s++) begin
          for (int b = 0; b < ((s < 2) ? 8 : 6); b++) wq.push_back(LANES*OPW'($urandom));
          send_w(0);
        end
      end
      begin
        int st;
        for (int i = 0; i < 32; i++) begin
          iq.push_back(OPW'($urandom)); pq.push_back(rand_psum(0));
        end
        send_i(0, st);
        check("pp_stalls", st, 0);
      end
    join
    repeat (4) tick();

    // Randomized traffic with gaps on both streams.
    for (int r = 0; r < 3; r++) begin
      len = int'($urandom_range(1, 8));
      cfg_len = AW'(len);
      fork
        begin
          for (int s = 0; s < 6; s++) begin
            int nb;
            nb = int'($urandom_range(1, 8));
            for (int b = 0; b < nb; b++) wq.push_back(LANES*OPW'($urandom));
            send_w(30);
          end
        end
        begin
          for (int i = 0; i < 6*len; i++) begin
            iq.push_back(OPW'($urandom)); pq.push_back(rand_psum(0));
          end
          send_i(30, stalls);
        end
      join
      repeat (4) tick();
    end

    // Reset in the middle of a pass, then reload and rerun.
    cfg_len = 4;
    for (int b = 0; b < 4; b++) wq.push_back(LANES*OPW'($urandom));
    send_w(0);
    wait_iready();
    iact_valid = 1; iact = OPW'($urandom); psum_in = rand_psum(0);
    tick();
    iact = OPW'($urandom); psum_in = rand_psum(0);
    tick();
    iact_valid = 0; rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    check("mid_rst_psum_valid", psum_valid, 0);
    check("mid_rst_iact_ready", iact_ready, 0);
    check("mid_rst_w_ready", w_ready, 1);
    tick();
    outs0 = outs;
    for (int b = 0; b < 4; b++) wq.push_back(LANES*OPW'($urandom));
    send_w(0);
    for (int i = 0; i < 4; i++) begin
      iq.push_back(OPW'($urandom)); pq.push_back(rand_psum(0));
    end
    send_i(0, stalls);
    repeat (5) tick();
    check("rerun_outputs", outs - outs0, 4);
    check("drained", outs, fires);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
